// File: rtl/trench_run_sequencer_if.sv
// Sensor-link handshake and symbol bus between a frame requester and the sequencer.
interface trench_run_sequencer_if;
    logic       start;
    logic [1:0] mode;
    logic       ready;
    logic [2:0] sensor_out;
    logic       frame_active;
    logic       frame_done;
    logic [7:0] frame_count;

    // Requester side: issues start/mode, observes the symbol stream.
    modport master (
        output start, mode,
        input  ready, sensor_out, frame_active, frame_done, frame_count
    );

    // Sequencer side: accepts requests and drives the symbol stream.
    modport slave (
        input  start, mode,
        output ready, sensor_out, frame_active, frame_done, frame_count
    );
endinterface

// File: rtl/trench_run_sequencer.sv
// Sensor symbol frame generator: plays one nominal/intercept/noise frame per
// accepted start, followed by an idle gap of IDLE_GAP zero symbols.
module trench_run_sequencer #(
    parameter int unsigned IDLE_GAP = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    trench_run_sequencer_if.slave      bus
);

    localparam int unsigned IDX_W = 3;
    localparam int unsigned GAP_W = 4;
    localparam int unsigned SYM_W = 3;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [1:0]         mode_q, mode_d;
    logic [SYM_W-1:0]   sensor_q, sensor_d;
    logic               ready_q, ready_d;
    logic               active_q, active_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Index of the final symbol for a frame type (mode 11 plays as nominal).
    function automatic logic [IDX_W-1:0] frame_last(input logic [1:0] m);
        logic [IDX_W-1:0] last;
        case (m)
            2'b01:   last = IDX_W'(6);
            2'b10:   last = IDX_W'(6);
            default: last = IDX_W'(7);
        endcase
        return last;
    endfunction

    // Symbol table for each frame type.
    function automatic logic [SYM_W-1:0] frame_sym(input logic [1:0] m,
                                                   input logic [IDX_W-1:0] i);
        logic [SYM_W-1:0] s;
        s = 3'd0;
        case (m)
            2'b01: begin
                case (i)
                    3'd0:    s = 3'd7;
                    3'd1:    s = 3'd7;
                    3'd2:    s = 3'd1;
                    3'd3:    s = 3'd2;
                    3'd4:    s = 3'd4;
                    3'd5:    s = 3'd5;
                    3'd6:    s = 3'd4;
                    default: s = 3'd0;
                endcase
            end
            2'b10: begin
                case (i)
                    3'd0:    s = 3'd7;
                    3'd1:    s = 3'd7;
                    3'd2:    s = 3'd7;
                    3'd3:    s = 3'd1;
                    3'd4:    s = 3'd2;
                    3'd5:    s = 3'd4;
                    3'd6:    s = 3'd4;
                    default: s = 3'd0;
                endcase
            end
            default: begin
                case (i)
                    3'd0:    s = 3'd7;
                    3'd1:    s = 3'd7;
                    3'd2:    s = 3'd1;
                    3'd3:    s = 3'd2;
                    3'd4:    s = 3'd0;
                    3'd5:    s = 3'd4;
                    3'd6:    s = 3'd0;
                    3'd7:    s = 3'd4;
                    default: s = 3'd0;
                endcase
            end
        endcase
        return s;
    endfunction

    // State and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            gap_q    <= '0;
            mode_q   <= '0;
            sensor_q <= '0;
            ready_q  <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            mode_q   <= mode_d;
            sensor_q <= sensor_d;
            ready_q  <= ready_d;
            active_q <= active_d;
            done_q   <= done_d;
            count_q  <= count_d;
        end
    end

    // Next state and next output values; outputs are computed one edge ahead
    // so the first symbol appears on the accepting edge.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        mode_d   = mode_q;
        sensor_d = '0;
        ready_d  = 1'b0;
        active_d = 1'b0;
        done_d   = 1'b0;
        count_d  = count_q;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (bus.start) begin
                    state_d  = SEND;
                    mode_d   = bus.mode;
                    idx_d    = '0;
                    sensor_d = frame_sym(bus.mode, IDX_W'(0));
                    active_d = 1'b1;
                    ready_d  = 1'b0;
                end
            end
            SEND: begin
                if (idx_q == frame_last(mode_q)) begin
                    count_d = count_q + CNT_W'(1);
                    // A one-symbol gap means ready returns on the same edge the gap starts.
                    if (IDLE_GAP <= 1) begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                    end else begin
                        state_d = GAP;
                        gap_d   = GAP_W'(1);
                    end
                end else begin
                    idx_d    = idx_q + IDX_W'(1);
                    sensor_d = frame_sym(mode_q, idx_q + IDX_W'(1));
                    active_d = 1'b1;
                    done_d   = ((idx_q + IDX_W'(1)) == frame_last(mode_q));
                end
            end
            GAP: begin
                if (gap_q >= GAP_W'(IDLE_GAP - 1)) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    assign bus.ready        = ready_q;
    assign bus.sensor_out   = sensor_q;
    assign bus.frame_active = active_q;
    assign bus.frame_done   = done_q;
    assign bus.frame_count  = count_q;

endmodule

// File: tb/tb_trench_run_sequencer.sv
// Directed bench for trench_run_sequencer with hand-written frame tables.
module tb_trench_run_sequencer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   done_seen;

    trench_run_sequencer_if bus ();

    trench_run_sequencer #(.IDLE_GAP(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_len(input logic [1:0] m);
        if (m == 2'b01 || m == 2'b10) return 7;
        return 8;
    endfunction

    function automatic int exp_sym(input logic [1:0] m, input int i);
        int nom [8];
        int icp [8];
        int noi [8];
        nom = '{7, 7, 1, 2, 0, 4, 0, 4};
        icp = '{7, 7, 1, 2, 4, 5, 4, 0};
        noi = '{7, 7, 7, 1, 2, 4, 4, 0};
        case (m)
            2'b01:   return icp[i];
            2'b10:   return noi[i];
            default: return nom[i];
        endcase
    endfunction

    // Wait for ready, request one frame, and optionally check every symbol.
    task automatic play_frame(input logic [1:0] m, input int cnt_after, input bit full);
        int n;
        int w;
        n = exp_len(m);
        w = 0;
        while (bus.ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        check("ready_before_start", 32'(bus.ready), 32'd1);
        bus.mode  = m;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.mode  = ~m;
        for (int i = 0; i < n; i++) begin
            if (full) begin
                check("sym",    32'(bus.sensor_out),   32'(exp_sym(m, i)));
                check("active", 32'(bus.frame_active), 32'd1);
                check("done",   32'(bus.frame_done),   32'(i == n - 1));
                check("busy",   32'(bus.ready),        32'd0);
            end
            if (bus.frame_done === 1'b1) done_seen++;
            bus.start = (i == 3);
            tick();
        end
        bus.start = 1'b0;
        check("gap_sym",    32'(bus.sensor_out),   32'd0);
        check("gap_active", 32'(bus.frame_active), 32'd0);
        check("count",      32'(bus.frame_count),  32'(cnt_after));
        if (full) begin
            check("gap_done",  32'(bus.frame_done), 32'd0);
            check("gap_ready", 32'(bus.ready),      32'd0);
            tick();
            check("gap2_sym",  32'(bus.sensor_out), 32'd0);
            check("ready_up",  32'(bus.ready),      32'd1);
        end
    endtask

    initial begin
        int base;
        n_checks  = 0;
        n_errors  = 0;
        done_seen = 0;
        bus.start = 1'b0;
        bus.mode  = 2'b00;
        rst       = 1'b1;
        #12;
        check("rst_sym",    32'(bus.sensor_out),   32'd0);
        check("rst_ready",  32'(bus.ready),        32'd1);
        check("rst_active", 32'(bus.frame_active), 32'd0);
        check("rst_done",   32'(bus.frame_done),   32'd0);
        check("rst_count",  32'(bus.frame_count),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        play_frame(2'b00, 1, 1'b1);
        play_frame(2'b01, 2, 1'b1);
        play_frame(2'b10, 3, 1'b1);
        play_frame(2'b11, 4, 1'b1);

        // Back-to-back with start held high: 10-cycle period, 2 zeros between frames.
        base      = 4;
        bus.mode  = 2'b00;
        bus.start = 1'b1;
        for (int c = 0; c < 30; c++) begin
            int pos;
            tick();
            pos = c % 10;
            check("b2b_sym",   32'(bus.sensor_out), 32'((pos < 8) ? exp_sym(2'b00, pos) : 0));
            check("b2b_ready", 32'(bus.ready),      32'(pos == 9));
            check("b2b_done",  32'(bus.frame_done), 32'(pos == 7));
        end
        bus.start = 1'b0;
        check("b2b_count", 32'(bus.frame_count), 32'(base + 3));

        // Reset during the 4th symbol aborts the frame immediately.
        tick();
        bus.mode  = 2'b00;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        check("pre_rst_sym", 32'(bus.sensor_out), 32'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_sym",    32'(bus.sensor_out),   32'd0);
        check("mid_rst_ready",  32'(bus.ready),        32'd1);
        check("mid_rst_count",  32'(bus.frame_count),  32'd0);
        check("mid_rst_active", 32'(bus.frame_active), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        done_seen = 0;
        play_frame(2'b00, 1, 1'b1);

        // Wrap: frames 2..256, checking the count at 255 and the wrap to 0.
        for (int f = 2; f <= 256; f++) begin
            play_frame((f % 2 == 0) ? 2'b11 : 2'b00, f % 256, (f >= 255));
        end
        check("wrap_done_pulses", 32'(done_seen), 32'd256);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
